// File: rtl/axi4_r_drop_arbiter.sv
// AXI4 R-channel sequencer: merges the buffered downstream R stream with locally
// generated error bursts for dropped reads, burst-atomic, round-robin at burst edges.
`timescale 1ns/1ps
module axi4_r_drop_arbiter #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arst,
  input  logic                      drop_valid,
  output logic                      drop_ready,
  input  logic [AXI_ID_WIDTH-1:0]   drop_id,
  input  logic [7:0]                drop_len,
  input  logic [AXI_USER_WIDTH-1:0] drop_user,
  input  logic [1:0]                drop_resp,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic [1:0]                m_axi4_rresp,
  input  logic                      m_axi4_rlast,
  input  logic [AXI_USER_WIDTH-1:0] m_axi4_ruser,
  input  logic                      m_axi4_rvalid,
  output logic                      m_axi4_rready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi4_rid,
  output logic [AXI_DATA_WIDTH-1:0] s_axi4_rdata,
  output logic [1:0]                s_axi4_rresp,
  output logic                      s_axi4_rlast,
  output logic [AXI_USER_WIDTH-1:0] s_axi4_ruser,
  output logic                      s_axi4_rvalid,
  input  logic                      s_axi4_rready
);

  typedef enum logic [1:0] {IDLE, PASS, ERR} state_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_USER_WIDTH-1:0] user;
    logic [1:0]                resp;
  } err_ctx_t;

  state_t   state, state_n;
  logic     rr_last, rr_last_n;   // 0: PASS granted last, 1: ERR granted last
  logic [7:0] cnt, cnt_n;
  err_ctx_t ctx, ctx_n;

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      cnt     <= '0;
      ctx     <= '0;
    end else begin
      state   <= state_n;
      rr_last <= rr_last_n;
      cnt     <= cnt_n;
      ctx     <= ctx_n;
    end
  end

  always_comb begin
    state_n       = state;
    rr_last_n     = rr_last;
    cnt_n         = cnt;
    ctx_n         = ctx;
    drop_ready    = 1'b0;
    m_axi4_rready = 1'b0;
    s_axi4_rvalid = 1'b0;
    s_axi4_rid    = '0;
    s_axi4_rdata  = '0;
    s_axi4_rresp  = '0;
    s_axi4_rlast  = 1'b0;
    s_axi4_ruser  = '0;
    unique case (state)
      IDLE: begin
        // Under contention the source opposite the last grant wins.
        if (m_axi4_rvalid && (!drop_valid || rr_last)) begin
          state_n   = PASS;
          rr_last_n = 1'b0;
        end else if (drop_valid) begin
          drop_ready = 1'b1;
          ctx_n      = '{id: drop_id, user: drop_user, resp: drop_resp};
          cnt_n      = drop_len;
          state_n    = ERR;
          rr_last_n  = 1'b1;
        end
      end
      PASS: begin
        s_axi4_rid    = m_axi4_rid;
        s_axi4_rdata  = m_axi4_rdata;
        s_axi4_rresp  = m_axi4_rresp;
        s_axi4_rlast  = m_axi4_rlast;
        s_axi4_ruser  = m_axi4_ruser;
        s_axi4_rvalid = m_axi4_rvalid;
        m_axi4_rready = s_axi4_rready;
        if (m_axi4_rvalid && s_axi4_rready && m_axi4_rlast) state_n = IDLE;
      end
      ERR: begin
        s_axi4_rvalid = 1'b1;
        s_axi4_rid    = ctx.id;
        s_axi4_ruser  = ctx.user;
        s_axi4_rresp  = ctx.resp;
        s_axi4_rlast  = (cnt == 8'd0);
        // Exit on the beat where cnt is 0, so cnt never wraps.
        if (s_axi4_rready) begin
          if (cnt == 8'd0) state_n = IDLE;
          else             cnt_n   = cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_r_drop_arbiter.sv
// Scoreboard bench for axi4_r_drop_arbiter: directed bursts push expected beats,
// a negedge monitor pops and compares every beat accepted by the master.
`timescale 1ns/1ps
module tb_axi4_r_drop_arbiter;
  localparam int DW = 32, IW = 4, UW = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          drop_valid = 0, drop_ready;
  logic [IW-1:0] drop_id = '0;
  logic [7:0]    drop_len = '0;
  logic [UW-1:0] drop_user = '0;
  logic [1:0]    drop_resp = '0;
  logic [IW-1:0] m_rid = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    m_rresp = '0;
  logic          m_rlast = 0, m_rvalid = 0, m_rready;
  logic [IW-1:0] s_rid;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast, s_rvalid;
  logic [UW-1:0] s_ruser;
  logic          s_rready = 1'b1;

  always #5 clk = ~clk;

  axi4_r_drop_arbiter #(.AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) dut (
    .axi4_aclk(clk), .axi4_arst(rst),
    .drop_valid(drop_valid), .drop_ready(drop_ready), .drop_id(drop_id),
    .drop_len(drop_len), .drop_user(drop_user), .drop_resp(drop_resp),
    .m_axi4_rid(m_rid), .m_axi4_rdata(m_rdata), .m_axi4_rresp(m_rresp),
    .m_axi4_rlast(m_rlast), .m_axi4_ruser(m_ruser), .m_axi4_rvalid(m_rvalid),
    .m_axi4_rready(m_rready),
    .s_axi4_rid(s_rid), .s_axi4_rdata(s_rdata), .s_axi4_rresp(s_rresp),
    .s_axi4_rlast(s_rlast), .s_axi4_ruser(s_ruser), .s_axi4_rvalid(s_rvalid),
    .s_axi4_rready(s_rready)
  );

  logic [UW-1:0] m_ruser = '0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_act, mon_exp;
  int errors = 0, checks = 0, mon_beats = 0, drop_hs = 0;
  int rmode = 0;  // 0: ready high, 1: random, 2: ready low

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master ready, changed away from both edges
  initial forever begin
    @(posedge clk); #2;
    case (rmode)
      0:       s_rready = 1'b1;
      1:       s_rready = 1'($urandom_range(0, 1));
      default: s_rready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && drop_valid && drop_ready) drop_hs++;
    if (!rst && s_rvalid && s_rready) begin
      mon_act = {s_rid, s_rdata, s_rresp, s_rlast, s_ruser};
      mon_beats++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got %0h expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("r_beat", 64'(mon_act), 64'(mon_exp));
      end
    end
  end

  task automatic push_drop(input logic [7:0] len, input logic [IW-1:0] id,
                           input logic [UW-1:0] user, input logic [1:0] resp);
    for (int i = 0; i <= int'(len); i++) begin
      logic l;
      l = (i == int'(len));
      exp_q.push_back({id, 32'h0, resp, l, user});
    end
  endtask

  task automatic push_pass(input int n, input logic [IW-1:0] id, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      logic l;
      l = (i == n - 1);
      exp_q.push_back({id, base + DW'(i), 2'b00, l, ~id});
    end
  endtask

  task automatic pass_burst(input int n, input logic [IW-1:0] id, input logic [DW-1:0] base,
                            input bit gaps);
    for (int i = 0; i < n; i++) begin
      bit hs;
      int t;
      if (gaps) repeat ($urandom_range(0, 2)) begin
        m_rvalid = 1'b0; @(posedge clk); #1;
      end
      m_rvalid = 1'b1; m_rid = id; m_rdata = base + DW'(i); m_rresp = 2'b00;
      m_rlast = (i == n - 1); m_ruser = ~id;
      hs = 0; t = 0;
      while (!hs && t < 2000) begin
        @(negedge clk);
        if (m_rready) begin
          hs = 1;
          chk("pass_zero_latency", {31'b0, s_rvalid, s_rdata}, {31'b0, 1'b1, m_rdata});
        end
        @(posedge clk); #1; t++;
      end
      if (!hs) begin
        checks++; errors++;
        $display("FAIL pass_timeout: got no m_rready expected handshake");
      end
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  task automatic do_drop(input logic [7:0] len, input logic [IW-1:0] id,
                         input logic [UW-1:0] user, input logic [1:0] resp);
    bit hs;
    int t;
    drop_valid = 1'b1; drop_len = len; drop_id = id; drop_user = user; drop_resp = resp;
    hs = 0; t = 0;
    while (!hs && t < 2000) begin
      @(negedge clk);
      hs = drop_ready;
      @(posedge clk); #1; t++;
    end
    drop_valid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL drop_timeout: got no drop_ready expected handshake");
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int h0, b0;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, b0;
    do_reset();
    @(negedge clk);
    chk("reset_outputs", {s_rvalid, m_rready, drop_ready, s_rid, s_rdata, s_rresp, s_rlast, s_ruser}, 64'd0);
    @(posedge clk); #1;

    // Single drop: 4 beats, consecutive, starting one cycle after drop handshake
    h0 = drop_hs;
    push_drop(8'd3, 4'hA, 4'h2, 2'b10);
    drop_valid = 1'b1; drop_len = 8'd3; drop_id = 4'hA; drop_user = 4'h2; drop_resp = 2'b10;
    @(negedge clk);
    chk("drop_ready_pulse", 64'(drop_ready), 64'd1);
    @(posedge clk); #1;
    drop_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("err_beat_consecutive", 64'(s_rvalid), 64'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("err_burst_end", 64'(s_rvalid), 64'd0);
    chk("drop_hs_once", 64'(drop_hs - h0), 64'd1);
    @(posedge clk); #1;
    chk("single_drop_empty", 64'(exp_q.size()), 64'd0);

    // Reset during the 3rd beat of an 8-beat error burst
    push_drop(8'd1, 4'h3, 4'h1, 2'b10);
    exp_q[exp_q.size()-1].last = 1'b0;   // beats 1-2 of an 8-beat burst
    do_drop(8'd7, 4'h3, 4'h1, 2'b10);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_midburst_rvalid", 64'(s_rvalid), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("reset_midburst_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure mid-burst
    b0 = mon_beats;
    push_drop(8'd5, 4'h3, 4'h7, 2'b11);
    do_drop(8'd5, 4'h3, 4'h7, 2'b11);
    @(posedge clk); #1 rmode = 2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_stable", {s_rvalid, s_rid, s_rlast, s_rdata}, {1'b1, 4'h3, 1'b0, 32'h0});
      @(posedge clk); #1;
    end
    rmode = 0;
    drain();
    chk("bp_beat_count", 64'(mon_beats - b0), 64'd6);

    // Boundaries
    push_drop(8'd0, 4'h5, 4'h9, 2'b10);
    do_drop(8'd0, 4'h5, 4'h9, 2'b10);
    drain();
    b0 = mon_beats;
    push_drop(8'd255, 4'hC, 4'h4, 2'b10);
    do_drop(8'd255, 4'hC, 4'h4, 2'b10);
    drain();
    chk("len255_beats", 64'(mon_beats - b0), 64'd256);

    // Passthrough with random valid/ready gaps
    rmode = 1;
    push_pass(4, 4'h5, 32'h1000_0000);
    pass_burst(4, 4'h5, 32'h1000_0000, 1'b1);
    drain();
    rmode = 0;

    // Contention from reset: PASS, DROP, PASS, DROP
    do_reset();
    push_pass(2, 4'h1, 32'h2000_0000);
    push_drop(8'd1, 4'h6, 4'h3, 2'b10);
    push_pass(3, 4'h2, 32'h3000_0000);
    push_drop(8'd0, 4'h7, 4'h8, 2'b10);
    fork
      begin
        pass_burst(2, 4'h1, 32'h2000_0000, 1'b0);
        pass_burst(3, 4'h2, 32'h3000_0000, 1'b0);
      end
      begin
        do_drop(8'd1, 4'h6, 4'h3, 2'b10);
        do_drop(8'd0, 4'h7, 4'h8, 2'b10);
      end
    join
    drain();

    // After a PASS grant, contention goes to the drop source first
    push_pass(1, 4'hE, 32'h4000_0000);
    pass_burst(1, 4'hE, 32'h4000_0000, 1'b0);
    drain();
    push_drop(8'd2, 4'h9, 4'h6, 2'b10);
    push_pass(2, 4'h4, 32'h5000_0000);
    fork
      pass_burst(2, 4'h4, 32'h5000_0000, 1'b0);
      do_drop(8'd2, 4'h9, 4'h6, 2'b10);
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
